// File: rtl/inst_rom_ctrl_if.sv
// ---------------------------------------------------------------------------
// inst_rom_ctrl_if
//
// Purpose:
//    Bundles the loader write port and the fetch read port of the
//    TinyRISC-V instruction memory into one interface. The master side is
//    whoever drives requests (loader + fetch stage). The slave side is the
//    memory controller itself.
//
// Signals:
//    wr_en_i    loader write request
//    wr_strb_i  byte-lane enables, bit k covers wr_data_i[8k+7:8k]
//    wr_addr_i  write byte address
//    wr_data_i  write data
//    rd_req_i   fetch read request
//    rd_addr_i  read byte address
//    rd_hold_i  fetch stall, freezes the read output register
//    rd_data_o  registered read data
//    rd_valid_o rd_data_o belongs to an accepted request
//    rd_err_o   accepted request was out of range or misaligned
// ---------------------------------------------------------------------------
interface inst_rom_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);

   logic                    wr_en_i;
   logic [DATA_WIDTH/8-1:0] wr_strb_i;
   logic [ADDR_WIDTH-1:0]   wr_addr_i;
   logic [DATA_WIDTH-1:0]   wr_data_i;

   logic                    rd_req_i;
   logic [ADDR_WIDTH-1:0]   rd_addr_i;
   logic                    rd_hold_i;

   logic [DATA_WIDTH-1:0]   rd_data_o;
   logic                    rd_valid_o;
   logic                    rd_err_o;

   // Requester side: loader and fetch stage
   modport master (
      output wr_en_i,
      output wr_strb_i,
      output wr_addr_i,
      output wr_data_i,
      output rd_req_i,
      output rd_addr_i,
      output rd_hold_i,
      input  rd_data_o,
      input  rd_valid_o,
      input  rd_err_o
   );

   // Memory controller side
   modport slave (
      input  wr_en_i,
      input  wr_strb_i,
      input  wr_addr_i,
      input  wr_data_i,
      input  rd_req_i,
      input  rd_addr_i,
      input  rd_hold_i,
      output rd_data_o,
      output rd_valid_o,
      output rd_err_o
   );

endinterface

// File: rtl/inst_rom_ctrl.sv
// ---------------------------------------------------------------------------
// inst_rom_ctrl
//
// Purpose:
//    Parametrised instruction memory for TinyRISC-V. The program loader
//    writes through a byte-strobed port; the fetch stage reads through a
//    registered, stallable port with one cycle of latency. A read that hits
//    the word being written in the same cycle sees the new bytes on the
//    strobed lanes (write-first per byte). Requests that are out of range
//    or misaligned return RST_DATA (a NOP) with rd_err_o set.
//
// Ports:
//    clk   single clock for both ports
//    rst   synchronous active-high reset (read output register only)
//    bus   inst_rom_ctrl_if.slave: write port, read port, read results
//
// Parameters:
//    DATA_WIDTH      word width in bits, multiple of 8
//    ADDR_WIDTH      byte-address width of both ports
//    MEM_ADDR_WIDTH  decoded byte-address bits, depth = 2^(MEM_ADDR_WIDTH-2)
//    RST_DATA        value presented after reset and on error
// ---------------------------------------------------------------------------
module inst_rom_ctrl #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    MEM_ADDR_WIDTH = 12,
   parameter logic [DATA_WIDTH-1:0] RST_DATA       = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   inst_rom_ctrl_if.slave       bus
);

   localparam int NUM_LANES = DATA_WIDTH / 8;
   localparam int IDX_WIDTH = MEM_ADDR_WIDTH - 2;
   localparam int DEPTH     = 1 << IDX_WIDTH;

   // Storage array, never cleared by reset
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Read output register
   logic [DATA_WIDTH-1:0] r_rdData;
   logic                  r_rdValid;
   logic                  r_rdErr;

   // Decoded address information
   logic                  w_wrInRange;
   logic                  w_wrAligned;
   logic                  w_wrAccept;
   logic [IDX_WIDTH-1:0]  w_wrIdx;

   logic                  w_rdInRange;
   logic                  w_rdAligned;
   logic                  w_rdOk;
   logic                  w_rdAccept;
   logic [IDX_WIDTH-1:0]  w_rdIdx;

   logic                  w_collide;
   logic [DATA_WIDTH-1:0] w_fwdWord;

   // Address decode. Range uses a shift rather than a slice so the check
   // stays legal whatever the relation between ADDR_WIDTH and
   // MEM_ADDR_WIDTH; every address bit above the decoded window must be 0.
   always_comb begin
      w_wrInRange = ((bus.wr_addr_i >> MEM_ADDR_WIDTH) == '0);
      w_wrAligned = (bus.wr_addr_i[1:0] == 2'b00);
      w_wrIdx     = bus.wr_addr_i[MEM_ADDR_WIDTH-1:2];
      w_wrAccept  = bus.wr_en_i && w_wrInRange && w_wrAligned;

      w_rdInRange = ((bus.rd_addr_i >> MEM_ADDR_WIDTH) == '0);
      w_rdAligned = (bus.rd_addr_i[1:0] == 2'b00);
      w_rdIdx     = bus.rd_addr_i[MEM_ADDR_WIDTH-1:2];
      w_rdOk      = w_rdInRange && w_rdAligned;
      w_rdAccept  = bus.rd_req_i && !bus.rd_hold_i;
   end

   // Write-first forwarding: when the read and a committing write target
   // the same word, each strobed lane takes the incoming byte and the
   // remaining lanes take the stored byte.
   always_comb begin
      w_collide = w_wrAccept && w_rdOk && (w_wrIdx == w_rdIdx);
      w_fwdWord = r_mem[w_rdIdx];
      if (w_collide) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if (bus.wr_strb_i[k]) begin
               w_fwdWord[8*k +: 8] = bus.wr_data_i[8*k +: 8];
            end
         end
      end
   end

   // Byte-lane write port. Deliberately independent of rst and rd_hold_i so
   // the loader can keep streaming while fetch is stalled or being reset.
   always_ff @(posedge clk) begin
      if (w_wrAccept) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if (bus.wr_strb_i[k]) begin
               r_mem[w_wrIdx][8*k +: 8] <= bus.wr_data_i[8*k +: 8];
            end
         end
      end
   end

   // Read output register. Reset beats hold, hold beats a request. With no
   // request the data is kept but valid/err drop so fetch sees a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdData  <= RST_DATA;
         r_rdValid <= 1'b0;
         r_rdErr   <= 1'b0;
      end else if (!bus.rd_hold_i) begin
         if (w_rdAccept) begin
            r_rdValid <= 1'b1;
            if (w_rdOk) begin
               r_rdData <= w_fwdWord;
               r_rdErr  <= 1'b0;
            end else begin
               r_rdData <= RST_DATA;
               r_rdErr  <= 1'b1;
            end
         end else begin
            r_rdValid <= 1'b0;
            r_rdErr   <= 1'b0;
         end
      end
   end

   assign bus.rd_data_o  = r_rdData;
   assign bus.rd_valid_o = r_rdValid;
   assign bus.rd_err_o   = r_rdErr;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_ctrl
//
// Purpose:
//    Directed self-checking bench for inst_rom_ctrl. Each scenario task
//    drives the interface right after a rising edge and compares outputs
//    1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_inst_rom_ctrl;

   logic clk;
   logic rst;

   int checkCount;
   int passCount;

   inst_rom_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   inst_rom_ctrl #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (32),
      .MEM_ADDR_WIDTH(12),
      .RST_DATA      (32'h0000_0013)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // 10 time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      bus.wr_en_i   = 1'b0;
      bus.wr_strb_i = 4'h0;
      bus.wr_addr_i = 32'h0;
      bus.wr_data_i = 32'h0;
      bus.rd_req_i  = 1'b0;
      bus.rd_addr_i = 32'h0;
      bus.rd_hold_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idleInputs();
      tick();
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'h13) $display("[TB] FAIL reset_data got %h want %h", bus.rd_data_o, 32'h13);
      else passCount++;
      checkCount++;
      if (bus.rd_valid_o !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", bus.rd_valid_o);
      else passCount++;
      checkCount++;
      if (bus.rd_err_o !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", bus.rd_err_o);
      else passCount++;
      rst = 1'b0;
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'h13 || bus.rd_valid_o !== 1'b0 || bus.rd_err_o !== 1'b0)
         $display("[TB] FAIL reset_release got %h/%b/%b want 00000013/0/0",
                  bus.rd_data_o, bus.rd_valid_o, bus.rd_err_o);
      else passCount++;
   endtask

   task automatic test_stream();
      for (int i = 0; i < 8; i++) begin
         bus.wr_en_i   = 1'b1;
         bus.wr_strb_i = 4'hF;
         bus.wr_addr_i = 32'(4 * i);
         bus.wr_data_i = 32'h1000_0000 + 32'(i);
         tick();
      end
      bus.wr_en_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.rd_req_i  = 1'b1;
         bus.rd_addr_i = 32'(4 * i);
         tick();
         checkCount++;
         if (bus.rd_data_o !== 32'h1000_0000 + 32'(i) || bus.rd_valid_o !== 1'b1 || bus.rd_err_o !== 1'b0)
            $display("[TB] FAIL stream_%0d got %h/%b/%b want %h/1/0", i,
                     bus.rd_data_o, bus.rd_valid_o, bus.rd_err_o, 32'h1000_0000 + 32'(i));
         else passCount++;
      end
      bus.rd_req_i = 1'b0;
      tick();
      checkCount++;
      if (bus.rd_valid_o !== 1'b0 || bus.rd_data_o !== 32'h1000_0007)
         $display("[TB] FAIL stream_idle got %h/%b want 10000007/0", bus.rd_data_o, bus.rd_valid_o);
      else passCount++;
   endtask

   task automatic test_strobe_collision();
      bus.wr_en_i   = 1'b1;
      bus.wr_strb_i = 4'hF;
      bus.wr_addr_i = 32'h8;
      bus.wr_data_i = 32'hAABB_CCDD;
      tick();
      bus.wr_strb_i = 4'b0101;
      bus.wr_data_i = 32'h1122_3344;
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = 32'h8;
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'hAA22_CC44) $display("[TB] FAIL collision_fwd got %h want %h", bus.rd_data_o, 32'hAA22_CC44);
      else passCount++;
      bus.wr_en_i = 1'b0;
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'hAA22_CC44) $display("[TB] FAIL collision_array got %h want %h", bus.rd_data_o, 32'hAA22_CC44);
      else passCount++;
      bus.rd_req_i = 1'b0;
   endtask

   task automatic test_hold();
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = 32'h4;
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'h1000_0001) $display("[TB] FAIL hold_pre got %h want %h", bus.rd_data_o, 32'h1000_0001);
      else passCount++;
      bus.rd_hold_i = 1'b1;
      bus.rd_addr_i = 32'h8;
      bus.wr_en_i   = 1'b1;
      bus.wr_strb_i = 4'hF;
      bus.wr_addr_i = 32'h4;
      bus.wr_data_i = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkCount++;
         if (bus.rd_data_o !== 32'h1000_0001 || bus.rd_valid_o !== 1'b1)
            $display("[TB] FAIL hold_cycle_%0d got %h/%b want 10000001/1", c, bus.rd_data_o, bus.rd_valid_o);
         else passCount++;
      end
      bus.wr_en_i   = 1'b0;
      bus.rd_hold_i = 1'b0;
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'hAA22_CC44 || bus.rd_valid_o !== 1'b1)
         $display("[TB] FAIL hold_release got %h/%b want aa22cc44/1", bus.rd_data_o, bus.rd_valid_o);
      else passCount++;
      bus.rd_addr_i = 32'h4;
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'hDEAD_BEEF) $display("[TB] FAIL hold_write_commit got %h want %h", bus.rd_data_o, 32'hDEAD_BEEF);
      else passCount++;
      bus.rd_req_i = 1'b0;
   endtask

   task automatic test_errors();
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = 32'h1000;
      tick();
      checkCount++;
      if (bus.rd_err_o !== 1'b1 || bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== 32'h13)
         $display("[TB] FAIL err_range got %h/%b/%b want 00000013/1/1", bus.rd_data_o, bus.rd_valid_o, bus.rd_err_o);
      else passCount++;
      bus.rd_addr_i = 32'h6;
      tick();
      checkCount++;
      if (bus.rd_err_o !== 1'b1 || bus.rd_data_o !== 32'h13)
         $display("[TB] FAIL err_align got %h/%b want 00000013/1", bus.rd_data_o, bus.rd_err_o);
      else passCount++;
      bus.rd_req_i  = 1'b0;
      bus.wr_en_i   = 1'b1;
      bus.wr_strb_i = 4'hF;
      bus.wr_addr_i = 32'h1000;
      bus.wr_data_i = 32'hFFFF_FFFF;
      tick();
      bus.wr_addr_i = 32'h2;
      tick();
      bus.wr_en_i   = 1'b0;
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = 32'h0;
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'h1000_0000 || bus.rd_err_o !== 1'b0)
         $display("[TB] FAIL err_write_dropped got %h/%b want 10000000/0", bus.rd_data_o, bus.rd_err_o);
      else passCount++;
      bus.rd_req_i = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = 32'h4;
      tick();
      bus.rd_hold_i = 1'b1;
      rst           = 1'b1;
      bus.wr_en_i   = 1'b1;
      bus.wr_strb_i = 4'hF;
      bus.wr_addr_i = 32'h20;
      bus.wr_data_i = 32'h0000_0055;
      tick();
      checkCount++;
      if (bus.rd_valid_o !== 1'b0 || bus.rd_data_o !== 32'h13 || bus.rd_err_o !== 1'b0)
         $display("[TB] FAIL rst_stall got %h/%b/%b want 00000013/0/0", bus.rd_data_o, bus.rd_valid_o, bus.rd_err_o);
      else passCount++;
      rst           = 1'b0;
      bus.rd_hold_i = 1'b0;
      bus.wr_en_i   = 1'b0;
      bus.rd_addr_i = 32'h1C;
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'h1000_0007 || bus.rd_valid_o !== 1'b1)
         $display("[TB] FAIL rst_mem_kept got %h/%b want 10000007/1", bus.rd_data_o, bus.rd_valid_o);
      else passCount++;
      bus.rd_addr_i = 32'h20;
      tick();
      checkCount++;
      if (bus.rd_data_o !== 32'h0000_0055) $display("[TB] FAIL rst_write_commit got %h want %h", bus.rd_data_o, 32'h55);
      else passCount++;
      bus.rd_req_i = 1'b0;
   endtask

   // Scenario sequence and summary
   initial begin
      checkCount = 0;
      passCount  = 0;
      test_reset();
      test_stream();
      test_strobe_collision();
      test_hold();
      test_errors();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
